// File: rtl/tm_pkg.sv
// Shared definitions for the tm_input_sequencer block.
//   tm_state_e     : sequencer FSM states
//   TM_HI_CYC_DEF  : default cycles tm_next is held high per pulse
//   TM_LO_CYC_DEF  : default minimum low cycles between pulses
//   tm_max()       : integer max, used to size the phase counter
package tm_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD_HI,
        ST_LOAD_LO,
        ST_DONE,
        ST_RUN_WAIT,
        ST_RUN_HI,
        ST_RUN_LO,
        ST_HALTED,
        ST_ERROR
    } tm_state_e;

    localparam int TM_HI_CYC_DEF = 2;
    localparam int TM_LO_CYC_DEF = 2;

    function automatic int tm_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tm_pulse_timer.sv
// Phase timer shared by the load and run pulse phases.
//   clock, reset : clock, asynchronous active-high reset
//   start        : reload the counter (asserted on the edge that enters a phase)
//   len          : phase length minus one, loaded on start
//   busy         : more cycles of the current phase remain after this one
// The counter saturates at zero rather than wrapping, so a phase whose
// owner forgets to leave never produces a spurious busy.
module tm_pulse_timer #(
    parameter int W = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] len,
    output logic         busy
);

    logic [W-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (start)
            cnt <= len;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/tm_input_sequencer.sv
// Loads a program word-by-word into a tape machine and then single-steps it.
//   clock, reset        : clock, asynchronous active-high reset
//   in_valid/in_data/in_last/in_ready : host word stream (valid/ready)
//   step                : one-cycle request for a machine step while running
//   compute_done        : machine halt indication
//   tm_data             : word presented to the machine
//   tm_next             : load/step strobe, HI_CYC high then at least LO_CYC low
//   tm_done             : one-cycle end-of-load strobe
//   busy                : not in IDLE, HALTED or ERROR
//   error               : program overflowed MAX_WORDS
//   word_count          : words accepted so far
// All outputs are registers or pure decodes of the state register.
module tm_input_sequencer
    import tm_pkg::*;
#(
    parameter int DW        = 4,
    parameter int MAX_WORDS = 64,
    parameter int HI_CYC    = TM_HI_CYC_DEF,
    parameter int LO_CYC    = TM_LO_CYC_DEF
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           in_valid,
    input  logic [DW-1:0]                  in_data,
    input  logic                           in_last,
    output logic                           in_ready,
    input  logic                           step,
    input  logic                           compute_done,
    output logic [DW-1:0]                  tm_data,
    output logic                           tm_next,
    output logic                           tm_done,
    output logic                           busy,
    output logic                           error,
    output logic [$clog2(MAX_WORDS+1)-1:0] word_count
);

    localparam int CW = $clog2(MAX_WORDS + 1);
    localparam int PW = $clog2(tm_max(HI_CYC, LO_CYC) + 1);

    tm_state_e     state, state_n;
    logic          last_q;
    logic          halt_pend;
    logic          accept;
    logic          tmr_start;
    logic [PW-1:0] tmr_len;
    logic          tmr_busy;

    tm_pulse_timer #(.W(PW)) u_timer (
        .clock (clock),
        .reset (reset),
        .start (tmr_start),
        .len   (tmr_len),
        .busy  (tmr_busy)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        tmr_start = 1'b0;
        tmr_len   = '0;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    // The word that would overflow is consumed but never loaded.
                    if (word_count == CW'(MAX_WORDS)) begin
                        state_n = ST_ERROR;
                    end else begin
                        accept  = 1'b1;
                        state_n = ST_LOAD_HI;
                    end
                end
            end
            ST_LOAD_HI:  if (!tmr_busy) state_n = ST_LOAD_LO;
            ST_LOAD_LO:  if (!tmr_busy) state_n = last_q ? ST_DONE : ST_IDLE;
            ST_DONE:     state_n = ST_RUN_WAIT;
            ST_RUN_WAIT: begin
                // Halt has priority over a coincident step.
                if (compute_done || halt_pend)
                    state_n = ST_HALTED;
                else if (step)
                    state_n = ST_RUN_HI;
            end
            ST_RUN_HI:   if (!tmr_busy) state_n = ST_RUN_LO;
            ST_RUN_LO:   if (!tmr_busy) state_n = ST_RUN_WAIT;
            default:     state_n = state;  // HALTED / ERROR hold until reset
        endcase

        // Reload the phase timer on every entry into a timed phase.
        if (state_n != state) begin
            case (state_n)
                ST_LOAD_HI, ST_RUN_HI: begin
                    tmr_start = 1'b1;
                    tmr_len   = PW'(HI_CYC - 1);
                end
                ST_LOAD_LO, ST_RUN_LO: begin
                    tmr_start = 1'b1;
                    tmr_len   = PW'(LO_CYC - 1);
                end
                default: begin
                    tmr_start = 1'b0;
                    tmr_len   = '0;
                end
            endcase
        end
    end

    // Word capture: tm_data only changes on an accepted handshake, which
    // can only happen in IDLE, so it is stable through the whole pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tm_data    <= '0;
            last_q     <= 1'b0;
            word_count <= '0;
        end else if (accept) begin
            tm_data    <= in_data;
            last_q     <= in_last;
            word_count <= word_count + 1'b1;
        end
    end

    // A halt seen mid-pulse is remembered so the pulse completes and the
    // halt takes effect at the following RUN_WAIT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            halt_pend <= 1'b0;
        else if (compute_done && (state == ST_RUN_HI || state == ST_RUN_LO))
            halt_pend <= 1'b1;
    end

    assign in_ready = (state == ST_IDLE);
    assign tm_next  = (state == ST_LOAD_HI) || (state == ST_RUN_HI);
    assign tm_done  = (state == ST_DONE);
    assign error    = (state == ST_ERROR);
    assign busy     = !((state == ST_IDLE) || (state == ST_HALTED) || (state == ST_ERROR));

endmodule
